// File: rtl/e_mdu_unit.sv
// E-stage multiply/divide unit. It holds the HI/LO registers and raises busy for a fixed latency per op.
// Defining MDU_MACC_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 7-10).
module e_mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MACC_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_MUL  = 3'd1,
        K_DIV  = 3'd2,
        K_MTHI = 3'd3,
        K_MTLO = 3'd4
    } op_kind_t;

    typedef enum logic [1:0] {
        M_SET = 2'd0,
        M_ADD = 2'd1,
        M_SUB = 2'd2
    } acc_mode_t;

    op_kind_t           op_kind_s;
    acc_mode_t          acc_mode_s;
    logic               is_signed_s;

    logic [2*WIDTH-1:0] a_ext_s;
    logic [2*WIDTH-1:0] b_ext_s;
    logic [2*WIDTH-1:0] prod_s;

    logic               a_neg_s;
    logic               b_neg_s;
    logic               div_zero_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH-1:0]   b_safe_s;
    logic [WIDTH-1:0]   quo_mag_s;
    logic [WIDTH-1:0]   rem_mag_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    logic [2*WIDTH-1:0] commit_val_s;

    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH-1:0] pend_r;
    logic               pend_wr_r;
    acc_mode_t          pend_mode_r;

    // Decode the op code into an operation class, signedness and accumulate mode.
    always_comb begin
        op_kind_s   = K_NONE;
        acc_mode_s  = M_SET;
        is_signed_s = 1'b0;
        case (mdu_op)
            OP_MULT:  begin op_kind_s = K_MUL; is_signed_s = 1'b1; end
            OP_MULTU: begin op_kind_s = K_MUL; end
            OP_DIV:   begin op_kind_s = K_DIV; is_signed_s = 1'b1; end
            OP_DIVU:  begin op_kind_s = K_DIV; end
            OP_MTHI:  begin op_kind_s = K_MTHI; end
            OP_MTLO:  begin op_kind_s = K_MTLO; end
`ifdef MDU_MACC_EN
            OP_MADD:  begin op_kind_s = K_MUL; is_signed_s = 1'b1; acc_mode_s = M_ADD; end
            OP_MADDU: begin op_kind_s = K_MUL; acc_mode_s = M_ADD; end
            OP_MSUB:  begin op_kind_s = K_MUL; is_signed_s = 1'b1; acc_mode_s = M_SUB; end
            OP_MSUBU: begin op_kind_s = K_MUL; acc_mode_s = M_SUB; end
`endif
            default:  begin op_kind_s = K_NONE; end
        endcase
    end

    // Full-width product; sign-extending to 2*WIDTH makes the truncated product correct for signed ops.
    always_comb begin
        a_ext_s = is_signed_s ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
        b_ext_s = is_signed_s ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Sign-magnitude divide: the quotient truncates toward zero and the remainder takes the dividend's sign.
    // The most-negative dividend divided by -1 wraps naturally to a quotient of -2^(WIDTH-1) and a remainder of 0.
    always_comb begin
        a_neg_s    = is_signed_s & src_a[WIDTH-1];
        b_neg_s    = is_signed_s & src_b[WIDTH-1];
        div_zero_s = (src_b == {WIDTH{1'b0}});
        abs_a_s    = a_neg_s ? ({WIDTH{1'b0}} - src_a) : src_a;
        abs_b_s    = b_neg_s ? ({WIDTH{1'b0}} - src_b) : src_b;
        b_safe_s   = div_zero_s ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b_s;
        quo_mag_s  = abs_a_s / b_safe_s;
        rem_mag_s  = abs_a_s % b_safe_s;
        quo_s      = (a_neg_s ^ b_neg_s) ? ({WIDTH{1'b0}} - quo_mag_s) : quo_mag_s;
        rem_s      = a_neg_s ? ({WIDTH{1'b0}} - rem_mag_s) : rem_mag_s;
    end

    // Value written to {HI,LO} at commit; accumulate modes use HI/LO as they stand at that edge.
    always_comb begin
        commit_val_s = pend_r;
        case (pend_mode_r)
            M_SET:   commit_val_s = pend_r;
            M_ADD:   commit_val_s = {hi_r, lo_r} + pend_r;
            M_SUB:   commit_val_s = {hi_r, lo_r} - pend_r;
            default: commit_val_s = pend_r;
        endcase
    end

    // Accept, count down and commit; new starts are ignored while an op is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            pend_r      <= {(2*WIDTH){1'b0}};
            pend_wr_r   <= 1'b0;
            pend_mode_r <= M_SET;
        end else if (busy_r) begin
            if (cnt_r == CNT_W'(1)) begin
                busy_r <= 1'b0;
                cnt_r  <= {CNT_W{1'b0}};
                if (pend_wr_r) begin
                    {hi_r, lo_r} <= commit_val_s;
                end else begin
                    {hi_r, lo_r} <= {hi_r, lo_r};
                end
            end else begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end else if (start) begin
            case (op_kind_s)
                K_MUL: begin
                    pend_r      <= prod_s;
                    pend_wr_r   <= 1'b1;
                    pend_mode_r <= acc_mode_s;
                    cnt_r       <= CNT_W'(MULT_CYCLES);
                    busy_r      <= 1'b1;
                end
                K_DIV: begin
                    pend_r      <= {rem_s, quo_s};
                    pend_wr_r   <= ~div_zero_s;
                    pend_mode_r <= M_SET;
                    cnt_r       <= CNT_W'(DIV_CYCLES);
                    busy_r      <= 1'b1;
                end
                K_MTHI:  hi_r <= src_a;
                K_MTLO:  lo_r <= src_a;
                default: busy_r <= 1'b0;
            endcase
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy   = busy_r;
    assign hi_out = hi_r;
    assign lo_out = lo_r;

endmodule

// File: tb/tb_e_mdu_unit.sv
// Randomised self-checking bench for e_mdu_unit against an arithmetic reference model of HI/LO.
// Accumulate ops are modelled only when MDU_MACC_EN is defined, mirroring the build.
module tb_e_mdu_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic [3:0]    mdu_op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          busy;
    logic [W-1:0]  hi_out;
    logic [W-1:0]  lo_out;

    logic [W-1:0]  m_hi;
    logic [W-1:0]  m_lo;
    int            total_cnt;
    int            bad_cnt;

    e_mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural effect of one accepted op on the model HI/LO; n is the expected busy length.
    task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int n);
        longint     sp;
        longint     q;
        longint     r;
        logic [63:0] up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        n  = 0;
        case (op)
            4'd1: begin {m_hi, m_lo} = 64'(sp); n = MC; end
            4'd2: begin {m_hi, m_lo} = up; n = MC; end
            4'd3: begin
                n = DC;
                if (b != 32'd0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            4'd4: begin
                n = DC;
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MDU_MACC_EN
            4'd7:  begin {m_hi, m_lo} = {m_hi, m_lo} + 64'(sp); n = MC; end
            4'd8:  begin {m_hi, m_lo} = {m_hi, m_lo} + up; n = MC; end
            4'd9:  begin {m_hi, m_lo} = {m_hi, m_lo} - 64'(sp); n = MC; end
            4'd10: begin {m_hi, m_lo} = {m_hi, m_lo} - up; n = MC; end
`endif
            default: n = 0;
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where busy has fallen.
    // With intrude set, a MULT is presented during the first busy cycle and must be ignored.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit intrude, input string tag);
        int n;
        int exp_n;
        model_op(op, a, b, exp_n);
        start  = 1'b1;
        mdu_op = op;
        src_a  = a;
        src_b  = b;
        @(negedge clk);
        if (intrude) begin
            start  = 1'b1;
            mdu_op = 4'd1;
            src_a  = 32'd3;
            src_b  = 32'd4;
        end else begin
            start  = 1'b0;
            mdu_op = 4'd0;
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
            start  = 1'b0;
            mdu_op = 4'd0;
        end
        start = 1'b0;
        check_eq({tag, ".cycles"}, 64'(n), 64'(exp_n));
        check_eq({tag, ".hi"}, {32'd0, hi_out}, {32'd0, m_hi});
        check_eq({tag, ".lo"}, {32'd0, lo_out}, {32'd0, m_lo});
    endtask

    logic [W-1:0] special [6];

    initial begin
        logic [3:0] rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        total_cnt = 0;
        bad_cnt   = 0;
        special[0] = 32'h0000_0000;
        special[1] = 32'hFFFF_FFFF;
        special[2] = 32'h8000_0000;
        special[3] = 32'h7FFF_FFFF;
        special[4] = 32'h0000_0001;
        special[5] = 32'h0000_0002;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        reset  = 1'b1;
        start  = 1'b0;
        mdu_op = 4'd0;
        src_a  = 32'd0;
        src_b  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("reset.busy", {63'd0, busy}, 64'd0);
        check_eq("reset.hi", {32'd0, hi_out}, 64'd0);
        check_eq("reset.lo", {32'd0, lo_out}, 64'd0);

        do_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult");
        check_eq("mult.vec", {32'd0, hi_out, lo_out} >> 0, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
        check_eq("multu.vec", {hi_out, lo_out}, {32'h0000_0001, 32'hFFFF_FFFE});
        do_op(4'd3, -32'sd7, 32'd2, 1'b0, "div");
        check_eq("div.vec", {hi_out, lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(4'd4, 32'd7, 32'd2, 1'b0, "divu");
        check_eq("divu.vec", {hi_out, lo_out}, {32'd1, 32'd3});
        do_op(4'd5, 32'h11, 32'd0, 1'b0, "mthi");
        do_op(4'd6, 32'h22, 32'd0, 1'b0, "mtlo");
        do_op(4'd3, 32'd5, 32'd0, 1'b0, "div0");
        check_eq("div0.vec", {hi_out, lo_out}, {32'h11, 32'h22});
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "divovf");
        check_eq("divovf.vec", {hi_out, lo_out}, {32'd0, 32'h8000_0000});

        // Reset in the third busy cycle of a MULT abandons it.
        start = 1'b1; mdu_op = 4'd1; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check_eq("rstmid.busy", {63'd0, busy}, 64'd0);
        check_eq("rstmid.hilo", {hi_out, lo_out}, 64'd0);
        repeat (MC) @(negedge clk);
        check_eq("rstmid.stale", {hi_out, lo_out}, 64'd0);
        do_op(4'd6, 32'd5, 32'd0, 1'b0, "rstmid.mtlo");

        do_op(4'd5, 32'd0, 32'd0, 1'b0, "macc.mthi");
        do_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, "macc.mtlo");
        do_op(4'd8, 32'd1, 32'd1, 1'b0, "maddu");
`ifdef MDU_MACC_EN
        check_eq("maddu.vec", {hi_out, lo_out}, {32'd1, 32'd0});
`else
        check_eq("maddu.vec", {hi_out, lo_out}, {32'd0, 32'hFFFF_FFFF});
`endif

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : 32'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : 32'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(0, 9));
            do_op(rop, ra, rb, 1'b0, $sformatf("rnd%0d.op%0d", i, rop));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
